// File: rtl/serial_adder.sv
// Digit-serial adder: sum = a + b + cin over WIDTH bits, DIGIT bits per clock.
// Optional `SERIAL_ADDER_OVF_EN adds a registered signed-overflow output ovf.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NUM = WIDTH / DIGIT;
    localparam int CW  = (NUM > 1) ? $clog2(NUM) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic [DIGIT:0]   digit_w;
    logic [DIGIT-1:0] s_w;
    logic             c_w;
    logic             last_w;

    assign digit_w = {1'b0, a_q[DIGIT-1:0]}
                   + {1'b0, b_q[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry_q};
    assign s_w     = digit_w[DIGIT-1:0];
    assign c_w     = digit_w[DIGIT];
    assign last_w  = (cnt_q == CW'(NUM - 1));

    // New digit enters at the top so after NUM cycles it sits in place.
    assign res_d = (res_q >> DIGIT) | (WIDTH'(s_w) << (WIDTH - DIGIT));

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;
    logic cmsb_w;
    assign cmsb_w = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ s_w[DIGIT-1];
    assign ovf    = ovf_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_BUSY: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    res_q   <= res_d;
                    carry_q <= c_w;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_w) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sum_q   <= res_d;
                        cout_q  <= c_w;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf_q   <= cmsb_w ^ c_w;
`endif
                    end
                end
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_BUSY;
                        a_q     <= a;
                        b_q     <= b;
                        res_q   <= '0;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder that computes `sum = a + b + cin` over `WIDTH` bits, processing `DIGIT` bits per clock through a single `DIGIT`-bit adder slice and a registered carry. It is the sequential, area-reduced successor of the single-bit full adder cell. Intended users are datapaths where adder area matters more than latency. A start/busy/done handshake hands off results to surrounding control logic.

## Interface
- `WIDTH`, default 8: operand and result width in bits; must be ≥ 1.
- `DIGIT`, default 1: bits added per cycle; must divide `WIDTH`. `NUM = WIDTH/DIGIT` is the cycles per operation.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: asynchronous reset, active-high.
- `start` input 1: request; sampled only in IDLE or DONE.
- `a` input WIDTH: operand A, captured on an accepted start.
- `b` input WIDTH: operand B, captured on an accepted start.
- `cin` input 1: carry in, captured on an accepted start.
- `busy` output 1: high while an operation is in progress.
- `done` output 1: one-cycle pulse when `sum`/`cout` are updated.
- `sum` output WIDTH: registered result; held until the next completion.
- `cout` output 1: registered carry out of bit `WIDTH-1`; held with `sum`.
- `ovf` output 1: only with `SERIAL_ADDER_OVF_EN`; see Configuration.

## Operation
- States:
  - IDLE: wait for `start`.
  - BUSY: one digit is processed per cycle.
  - DONE: single cycle; `done` is high.
- Accepted start (`start`=1 in IDLE or DONE):
  - Load `a` and `b` into shift registers.
  - Load the carry register with `cin`.
  - Clear the digit counter.
  - Move to BUSY.
- `start` during BUSY is ignored. There is no queueing, and the operands in flight are unaffected.
- Each BUSY cycle:
  - Compute `{c, s} = a_sh[DIGIT-1:0] + b_sh[DIGIT-1:0] + carry`, with the result `DIGIT+1` bits wide.
  - Shift both operand registers right by `DIGIT`.
  - Shift `s` into the working result from the MSB side.
  - Set `carry <= c` and increment the counter.
- On the cycle where the counter reaches `NUM-1`:
  - The final digit is processed.
  - `sum` is loaded from the full working result and `cout` from the final carry.
  - The state moves to DONE.
- DONE → IDLE if `start`=0. DONE → BUSY if `start`=1, which gives back-to-back operation.
- Arithmetic is unsigned modulo 2^WIDTH. `cout` is bit WIDTH of the true sum.
- `sum`/`cout` do not change during BUSY. The previous result stays visible.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0. Counter, operand and carry registers are all 0.
- Reset is asynchronous. Asserting it mid-operation aborts immediately, with no `done` and outputs cleared. The first start is accepted on the first rising edge after deassertion.
- Start accepted at edge k:
  - `busy`=1 from edge k to edge k+NUM.
  - `sum`/`cout` update at edge k+NUM.
  - `done`=1 from edge k+NUM to edge k+NUM+1.
- Latency is `NUM` cycles from start edge to result. Throughput is one result per `NUM+1` cycles when `start` is held high.
- `busy` and `done` are never high together.
- `WIDTH`=`DIGIT`: `NUM`=1, so BUSY lasts exactly one cycle.

## Configuration
- `SERIAL_ADDER_OVF_EN` defined:
  - Adds output `ovf`, reset to 0.
  - `ovf` = signed two's-complement overflow, i.e. carry into bit `WIDTH-1` XOR `cout`.
  - Registered and updated at the same edge as `sum`; held with it.
- Not defined: no `ovf` port and no extra logic. All other behaviour is identical.

## Test plan
- `WIDTH`=8, `DIGIT`=1, operands `a`=8'hFF, `b`=8'h01, `cin`=0, start at edge k:
  - `busy` is high for 8 cycles.
  - `done` pulses after edge k+8.
  - `sum`=8'h00, `cout`=1.
- Carry-in and back-to-back operation:
  - `a`=8'h5A, `b`=8'hA5, `cin`=1 gives `sum`=8'h00, `cout`=1.
  - With `start` held high, the second operation `a`=8'h12, `b`=8'h34, `cin`=0 gives `sum`=8'h46, `cout`=0.
  - `done` pulses exactly 9 cycles apart.
- Start while busy:
  - Sequence: start with 8'h10 + 8'h20, then pulse `start` with 8'hFF + 8'hFF at BUSY cycle 3.
  - Required: a single `done`, `sum`=8'h30, `cout`=0, and no second operation.
- Reset mid-operation:
  - Assert `rst` at BUSY cycle 4, between clock edges.
  - Required: `busy`, `sum`, `cout` go to 0 immediately, and no `done` follows.
  - After release, a fresh 8'h01 + 8'h01 gives `sum`=8'h02.
- `WIDTH`=16, `DIGIT`=4, operands 16'hFFFF + 16'h0001:
  - `busy` is high for 4 cycles.
  - `sum`=16'h0000, `cout`=1.
- With `SERIAL_ADDER_OVF_EN`, `WIDTH`=8:
  - 8'h7F + 8'h01 gives `ovf`=1, `sum`=8'h80.
  - 8'hFF + 8'h01 gives `ovf`=0, `cout`=1.
